// File: rtl/demux_frame_if.sv
// Frame controller to downstream 1-to-4 demux bundle.
// Ports: rx in; sel, dout, dvalid, frame_done, frame_err out.
interface demux_frame_if;
  logic       rx;
  logic [1:0] sel;
  logic       dout;
  logic       dvalid;
  logic       frame_done;
  logic       frame_err;

  modport master (
    input  rx,
    output sel, dout, dvalid, frame_done, frame_err
  );

  modport slave (
    output rx,
    input  sel, dout, dvalid, frame_done, frame_err
  );
endinterface

// File: rtl/demux_frame_ctrl.sv
// Serial frame receiver steering payload bits to a 1-to-4 demux.
// Ports: clk, rst_n (async low), bus (rx in; sel/dout/dvalid/done/err out).
module demux_frame_ctrl #(
  parameter int DATA_BITS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  demux_frame_if.master bus
);

  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    PAR,
    STOP
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    shadow_q;
  logic          abit_q;
  logic          par_q;
  logic [1:0]    sel_q;
  logic          dout_q;
  logic          dvalid_q;
  logic          done_q;
  logic          err_q;

  logic          last_d;
  logic          rx;

  assign rx     = bus.rx;
  assign last_d = (cnt_q == CW'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= 2'b00;
      abit_q   <= 1'b0;
      par_q    <= 1'b0;
      sel_q    <= 2'b00;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx) begin
            state_q <= ADDR;
            abit_q  <= 1'b0;
            par_q   <= 1'b0;
          end
        end
        ADDR: begin
          shadow_q <= {shadow_q[0], rx};
          par_q    <= par_q ^ rx;
          abit_q   <= 1'b1;
          if (abit_q) begin
            // A0 is on rx now, so bypass the shadow for it.
            sel_q   <= {shadow_q[0], rx};
            cnt_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          dout_q   <= rx;
          dvalid_q <= 1'b1;
          par_q    <= par_q ^ rx;
          cnt_q    <= cnt_q + 1'b1;
          if (last_d) state_q <= PAR;
        end
        PAR: begin
          par_q   <= par_q ^ rx;
          state_q <= STOP;
        end
        STOP: begin
          // The stop bit is never taken as a new start bit.
          if (rx && !par_q) done_q <= 1'b1;
          else              err_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.dout       = dout_q;
  assign bus.dvalid     = dvalid_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;

endmodule

// File: doc/demux_frame_ctrl.md
DEMUX_FRAME_CTRL -- requirements
Module: demux_frame_ctrl

Interface
REQ-001 Parameter: DATA_BITS, default 8, number of payload bits per frame (legal range 1..16).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 rx  input  1  serial frame input, one bit sampled per clk; idles high.
REQ-005 sel  output  2  channel select driven to the downstream 1-to-4 demux sel port.
REQ-006 dout  output  1  payload bit driven to the downstream demux data input.
REQ-007 dvalid  output  1  high for exactly the cycles in which dout carries a payload bit.
REQ-008 frame_done  output  1  one-cycle pulse: frame received with good parity and stop bit.
REQ-009 frame_err  output  1  one-cycle pulse: frame received with bad parity or bad stop bit.

Function
REQ-010 Frame format, one bit per cycle: start (0), A1, A0 (MSB first), DATA_BITS payload bits (MSB first), even-parity bit over A1, A0 and the payload, stop (1).
REQ-011 States: IDLE, ADDR, DATA, PAR, STOP; all outputs are registered.
REQ-012 IDLE: rx=1 stays in IDLE; rx=0 is taken as the start bit and moves to ADDR.
REQ-013 ADDR: shifts 2 bits into a shadow address register; after A0 is sampled, moves to DATA and loads sel from the shadow on that same edge.
REQ-014 DATA: each sampled payload bit appears on dout with dvalid=1 on the following edge, so latency is 1 cycle; moves to PAR after DATA_BITS bits.
REQ-015 Payload counter is ceil(log2(DATA_BITS+1)) bits wide and is cleared on entry to DATA.
REQ-016 dvalid is high for exactly DATA_BITS consecutive cycles per frame and low in all other cycles.
REQ-017 dout holds its last value when dvalid=0.
REQ-018 sel changes only on the ADDR->DATA edge.
REQ-019 sel is stable from at least one cycle before the first dvalid until after the last dvalid, and is held between frames.
REQ-020 Parity accumulator is the XOR of A1, A0, all payload bits and the parity bit; zero means good parity.
REQ-021 PAR: samples the parity bit, then moves to STOP.
REQ-022 STOP outcome, registered one cycle after the stop bit:
  - rx=1 and parity good: frame_done=1.
  - rx=0, or parity bad: frame_err=1, frame_done=0.
  - In every case the FSM returns to IDLE.
REQ-023 frame_done and frame_err are never high in the same cycle.
REQ-024 A stop bit of 0 is not reinterpreted as a start bit; the earliest next start bit is the cycle after STOP.
REQ-025 Back-to-back frames with no idle gap are legal: the start bit is accepted in the cycle immediately after STOP.
REQ-026 Payload bits are forwarded before the parity check completes; frame_err only flags the frame, it does not retract data.

Reset
REQ-027 rst_n low immediately and asynchronously forces: FSM=IDLE, sel=2'b00, dout=0, dvalid=0, frame_done=0, frame_err=0, counters, shadow and parity cleared.
REQ-028 Reset asserted mid-frame discards the frame; after release the block waits in IDLE for a new start bit.
REQ-029 The first rx sample taken after rst_n deasserts is treated as IDLE-state input.

Verification
REQ-030 Reset check: assert rst_n=0 mid-DATA -> all outputs 0 within the same cycle; after release, rx held at 1 for 20 cycles -> no dvalid.
REQ-031 Good frame, DATA_BITS=8, addr=2'b10, data=8'hA5, parity=1, stop=1 -> sel=2'b10 before the first dvalid; dout sequence 1,0,1,0,0,1,0,1 on 8 consecutive dvalid cycles; then frame_done pulse only.
REQ-032 Parity error: same frame with parity=0 -> 8 dvalid cycles still produced; frame_err pulse; frame_done stays 0.
REQ-033 Stop error: good frame with stop=0 and rx=1 afterward -> frame_err pulse; no new frame starts from the stop bit.
REQ-034 Back-to-back frames: addr 2'b01 then addr 2'b11 with zero idle gap -> sel goes 01->11 only between the two dvalid bursts; two frame_done pulses.
REQ-035 Address sweep: frames to addresses 00, 01, 10, 11 -> the downstream demux output bit selected in each frame equals the frame address; all other demux outputs stay 0.
